// File: rtl/toggle_pulse_gen_if.sv
// Button-side bundle of toggle_pulse_gen: raw button in, conditioned pulse/level/count out.
// master drives the button; slave is the conditioner.
interface toggle_pulse_gen_if;
    logic       btn_in;
    logic       t_pulse;
    logic       btn_level;
    logic [7:0] press_cnt;

    modport master (output btn_in, input t_pulse, btn_level, press_cnt);
    modport slave  (input btn_in, output t_pulse, btn_level, press_cnt);
endinterface

// File: rtl/toggle_pulse_gen.sv
// Turns a bouncy button into one clean t_pulse per press (plus optional auto-repeat while held),
// via a 2-flop synchronizer, a debounce counter and a press/release FSM.
module toggle_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_CYCLES   = 0,
    parameter int CNT_W           = 16
) (
    input  logic                clk,
    input  logic                rst,
    toggle_pulse_gen_if.slave   bus
);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam bit               REP_EN   = (REPEAT_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        PRESSED     = 2'd2,
        DEB_RELEASE = 2'd3
    } state_t;

    state_t           state;
    logic             s1, s2;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] rep_cnt;
    logic             t_pulse_q;
    logic             level_q;
    logic [7:0]       press_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            state     <= IDLE;
            deb_cnt   <= '0;
            rep_cnt   <= '0;
            t_pulse_q <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 8'd0;
        end else begin
            s1        <= bus.btn_in;
            s2        <= s1;
            t_pulse_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state   <= DEB_PRESS;
                        deb_cnt <= '0;
                    end
                end
                DEB_PRESS: begin
                    if (!s2) begin
                        state <= IDLE;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= PRESSED;
                        t_pulse_q <= 1'b1;
                        level_q   <= 1'b1;
                        press_q   <= press_q + 8'd1;
                        rep_cnt   <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s2) begin
                        state   <= DEB_RELEASE;
                        deb_cnt <= '0;
                    end else if (REP_EN) begin
                        // repeat pulses are not presses, so press_q is left alone
                        if (rep_cnt == REP_LAST) begin
                            t_pulse_q <= 1'b1;
                            rep_cnt   <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                end
                DEB_RELEASE: begin
                    if (s2) begin
                        state   <= PRESSED;
                        rep_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= IDLE;
                        level_q <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.t_pulse   = t_pulse_q;
    assign bus.btn_level = level_q;
    assign bus.press_cnt = press_q;
endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Bench for toggle_pulse_gen: two instances (no repeat / repeat=3), expected pulses queued
// at stimulus time with their cycle and press count, popped when a pulse shows up.
module tb_toggle_pulse_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   pulses_a = 0;

    typedef struct {
        int cyc;
        int cnt;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    toggle_pulse_gen_if ifa ();
    toggle_pulse_gen_if ifb ();

    toggle_pulse_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave));
    toggle_pulse_gen #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (ifa.t_pulse === 1'b1) begin
            pulses_a++;
            if (qa.size() == 0) chk("unexpected_pulse_a", int'(ifa.t_pulse), 0);
            else begin
                exp_t e;
                e = qa.pop_front();
                chk("pulse_a_cycle", cyc, e.cyc);
                chk("pulse_a_cnt", int'(ifa.press_cnt), e.cnt);
            end
        end
        if (ifb.t_pulse === 1'b1) begin
            if (qb.size() == 0) chk("unexpected_pulse_b", int'(ifb.t_pulse), 0);
            else begin
                exp_t e;
                e = qb.pop_front();
                chk("pulse_b_cycle", cyc, e.cyc);
                chk("pulse_b_cnt", int'(ifb.press_cnt), e.cnt);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step(2);
        chk("rst_t_pulse_a", int'(ifa.t_pulse), 0);
        chk("rst_level_a", int'(ifa.btn_level), 0);
        chk("rst_cnt_a", int'(ifa.press_cnt), 0);
        chk("rst_cnt_b", int'(ifb.press_cnt), 0);
        rst = 1'b0;
    endtask

    initial begin
        int c0;
        int p0;
        ifa.btn_in = 1'b0;
        ifb.btn_in = 1'b0;

        // 1: clean hold, single pulse after edge 7
        do_reset();
        c0 = cyc;
        ifa.btn_in = 1'b1;
        qa.push_back('{c0 + 7, 1});
        step(6);
        chk("t1_level_before", int'(ifa.btn_level), 0);
        step(1);
        chk("t1_level_rise", int'(ifa.btn_level), 1);
        step(13);
        chk("t1_cnt", int'(ifa.press_cnt), 1);
        ifa.btn_in = 1'b0;
        step(12);
        chk("t1_level_after_release", int'(ifa.btn_level), 0);

        // 2: short glitch is rejected
        do_reset();
        ifa.btn_in = 1'b1;
        step(2);
        ifa.btn_in = 1'b0;
        step(10);
        chk("t2_level", int'(ifa.btn_level), 0);
        chk("t2_cnt", int'(ifa.press_cnt), 0);

        // 3: release glitch keeps the press, real release drops level after edge 7
        c0 = cyc;
        ifa.btn_in = 1'b1;
        qa.push_back('{c0 + 7, 1});
        step(10);
        ifa.btn_in = 1'b0;
        step(2);
        ifa.btn_in = 1'b1;
        step(10);
        chk("t3_level_glitch", int'(ifa.btn_level), 1);
        chk("t3_cnt_glitch", int'(ifa.press_cnt), 1);
        ifa.btn_in = 1'b0;
        step(6);
        chk("t3_level_before_fall", int'(ifa.btn_level), 1);
        step(1);
        chk("t3_level_fall", int'(ifa.btn_level), 0);
        step(5);

        // 4: auto-repeat every 3 cycles after the press pulse
        do_reset();
        c0 = cyc;
        ifb.btn_in = 1'b1;
        qb.push_back('{c0 + 7, 1});
        qb.push_back('{c0 + 10, 1});
        qb.push_back('{c0 + 13, 1});
        qb.push_back('{c0 + 16, 1});
        step(16);
        ifb.btn_in = 1'b0;
        step(12);
        chk("t4_cnt", int'(ifb.press_cnt), 1);
        chk("t4_level", int'(ifb.btn_level), 0);
        chk("t4_queue_drained", qb.size(), 0);

        // 5: reset mid-debounce, held button gets a fresh full latency
        do_reset();
        ifa.btn_in = 1'b1;
        step(4);
        rst = 1'b1;
        #1;
        chk("t5_rst_level", int'(ifa.btn_level), 0);
        chk("t5_rst_cnt", int'(ifa.press_cnt), 0);
        step(2);
        chk("t5_rst_pulse", int'(ifa.t_pulse), 0);
        rst = 1'b0;
        c0 = cyc;
        qa.push_back('{c0 + 7, 1});
        step(10);
        chk("t5_cnt", int'(ifa.press_cnt), 1);
        ifa.btn_in = 1'b0;
        step(12);

        // 6: 257 presses, counter wraps through 0
        do_reset();
        p0 = pulses_a;
        for (int k = 0; k < 257; k++) begin
            c0 = cyc;
            ifa.btn_in = 1'b1;
            qa.push_back('{c0 + 7, (k + 1) % 256});
            step(9);
            if (k == 255) chk("t6_wrap_256", int'(ifa.press_cnt), 0);
            if (k == 256) chk("t6_wrap_257", int'(ifa.press_cnt), 1);
            ifa.btn_in = 1'b0;
            step(9);
        end
        chk("t6_pulse_total", pulses_a - p0, 257);
        chk("final_queue_a", qa.size(), 0);
        chk("final_queue_b", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/toggle_pulse_gen.md
Name: toggle_pulse_gen

Overview:
- Conditions a raw, bouncy push-button or level input into a clean single-cycle toggle-enable pulse.
- The pulse drives the t input of the downstream toggle flip-flop stage directly, so that one physical press gives exactly one toggle.
- Internals: 2-flop synchronizer, debounce counter and press/release FSM.
- Optional auto-repeat emits further pulses while the button stays held.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive synchronized samples at the same level needed to accept a press or a release; legal range >= 2.
- REPEAT_CYCLES, 0, auto-repeat pulse period in cycles while held; 0 disables auto-repeat, otherwise legal range >= 2.
- CNT_W, 16, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_CYCLES).

Ports:
- clk  input  1  single system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- btn_in  input  1  raw asynchronous button/level input, active-high.
- t_pulse  output  1  registered one-cycle toggle-enable pulse to the T flip-flop stage.
- btn_level  output  1  registered debounced button level.
- press_cnt  output  8  count of accepted presses; auto-repeat pulses are not counted.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous, active-high.
- Reset clears everything to 0: both synchronizer flops, the debounce counter, the repeat counter, t_pulse, btn_level and press_cnt. The FSM goes to IDLE.
- Synchronizer: btn_in passes through 2 flops (s1 -> s2). The FSM sees only s2.
- FSM states: IDLE, DEB_PRESS, PRESSED, DEB_RELEASE.
- IDLE:
  - s2=1 -> DEB_PRESS, debounce counter = 0.
  - Otherwise stay in IDLE.
- DEB_PRESS:
  - s2=0 -> IDLE. No pulse.
  - s2=1 with counter == DEBOUNCE_CYCLES-1 -> PRESSED. On the same edge: t_pulse=1, btn_level=1, press_cnt+1, repeat counter = 0.
  - s2=1 otherwise -> counter+1.
- PRESSED:
  - s2=0 -> DEB_RELEASE, debounce counter = 0.
  - s2=1 and REPEAT_CYCLES>0: the repeat counter increments each cycle. When it reaches REPEAT_CYCLES-1: t_pulse=1 for one cycle and the repeat counter returns to 0.
- DEB_RELEASE:
  - s2=1 -> PRESSED, repeat counter = 0. No pulse, no count.
  - s2=0 with counter == DEBOUNCE_CYCLES-1 -> IDLE, btn_level=0.
  - s2=0 otherwise -> counter+1.
- btn_level is 1 exactly while the FSM is in PRESSED or DEB_RELEASE.
- t_pulse is high for exactly 1 cycle per event and never 2 consecutive cycles.
- Latency: btn_in goes high and stays high, first sampling edge = edge 1. t_pulse is high for the cycle following edge DEBOUNCE_CYCLES+3.
  - Edges 1-2 are the synchronizer.
  - Edge 3 enters DEB_PRESS.
- Release latency, measured the same way from the first edge that samples btn_in=0: btn_level falls after edge DEBOUNCE_CYCLES+3.
- press_cnt wraps 255 -> 0.
- Reset asserted mid-debounce or mid-repeat:
  - Immediate clear; any partial count is discarded.
  - After reset deasserts with btn_in already high, a full press latency is required before the pulse, so a held button produces a fresh pulse.
- Counters never exceed their terminal value. No other output changes except on the transitions listed above.

Test Plan:
1. D=4, R=0. Reset, then hold btn_in=1 for 20 cycles -> t_pulse is a single 1-cycle high after edge 7; btn_level rises on the same edge; press_cnt=1; no further pulses.
2. D=4. btn_in high for 2 cycles, then low for 10 -> t_pulse never asserts, btn_level=0, press_cnt=0, FSM returns to IDLE.
3. D=4, in PRESSED. btn_in low for 2 cycles, then high again -> no pulse, btn_level stays 1, press_cnt unchanged. Then low for 10 cycles -> btn_level falls after edge 7 counted from the first low-sampling edge.
4. D=4, R=3. Hold btn_in high for 16 cycles -> pulses after edges 7, 10, 13 and 16; press_cnt=1 throughout.
5. D=4. Assert rst during DEB_PRESS with btn_in kept high, then deassert -> all outputs 0 during reset; the first pulse appears after edge 7 counted from the first edge after reset release.
6. D=4. Apply 257 clean press/release cycles -> press_cnt reads 0 after press 256 and 1 after press 257; exactly 257 t_pulses.
